tdc_spi_slave: RTL and testbench

//  SPI responder (target) for the TDC command link: the far end of our 8-bit SPI master.

---
 rtl/tdc_spi_slave_if.sv | 34 +++
 rtl/tdc_spi_slave.sv | 171 +++++++++++++++++
 tb/tb_tdc_spi_slave.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_spi_slave_if.sv
// Bus bundle for the TDC SPI responder: external SPI pins, TX/RX byte ports and frame status.
interface tdc_spi_slave_if;
  // SPI pins (master side drives sck/cs_n/mosi asynchronously)
  logic       sck_in;
  logic       cs_n_in;
  logic       mosi_in;
  logic       miso;
  logic       miso_oe;
  // TX byte handshake: a byte transfers on a clk edge where tx_load and tx_ready are both 1;
  // tx_load with tx_ready=0 is ignored, tx_ready drops the cycle after a transfer.
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  // RX byte and frame status
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_start;
  logic       frame_end;
  logic [7:0] byte_count;
  logic       tx_underrun;
  logic [1:0] state_dbg;

  modport slave (
    input  sck_in, cs_n_in, mosi_in, tx_data, tx_load,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, frame_start, frame_end,
           byte_count, tx_underrun, state_dbg
  );

  modport master (
    output sck_in, cs_n_in, mosi_in, tx_data, tx_load,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, frame_start, frame_end,
           byte_count, tx_underrun, state_dbg
  );
endinterface

// File: rtl/tdc_spi_slave.sv
// SPI mode-0 responder: oversamples sck/cs_n/mosi in the clk domain, shifts bytes MSB-first,
// strobes received bytes and serves replies from a one-deep TX buffer.
module tdc_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEFAULT_TX  = 8'h00
) (
  input logic             clk,
  input logic             rst,
  tdc_spi_slave_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_CS_HIGH = 2'd0,
    IDLE         = 2'd1,
    SHIFT        = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_e     state_q, state_d;
  logic [7:0] shift_tx_q, shift_tx_d;
  logic [6:0] shift_rx_q, shift_rx_d;
  logic [2:0] bit_ctr_q, bit_ctr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_end_q, frame_end_d;
  logic [7:0] byte_count_q, byte_count_d;
  logic       tx_underrun_q, tx_underrun_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_ready_q, tx_ready_d;
  logic       reload;

  // cs_n synchronizer resets low so a master still holding cs_n after rst is not seen as idle
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi_in};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_CS_HIGH;
      shift_tx_q    <= '0;
      shift_rx_q    <= '0;
      bit_ctr_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      byte_count_q  <= '0;
      tx_underrun_q <= 1'b0;
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      shift_tx_q    <= shift_tx_d;
      shift_rx_q    <= shift_rx_d;
      bit_ctr_q     <= bit_ctr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      byte_count_q  <= byte_count_d;
      tx_underrun_q <= tx_underrun_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_tx_d    = shift_tx_q;
    shift_rx_d    = shift_rx_q;
    bit_ctr_d     = bit_ctr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    byte_count_d  = byte_count_q;
    tx_underrun_d = tx_underrun_q;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    reload        = 1'b0;

    case (state_q)
      WAIT_CS_HIGH: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d       = SHIFT;
          frame_start_d = 1'b1;
          byte_count_d  = '0;
          tx_underrun_d = 1'b0;
          bit_ctr_d     = '0;
          reload        = 1'b1;
        end
      end
      SHIFT: begin
        // cs_n release takes priority over a coincident sck edge
        if (cs_rise) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          bit_ctr_d   = '0;
        end else if (sck_rise) begin
          shift_rx_d = {shift_rx_q[5:0], mosi_s};
          bit_ctr_d  = bit_ctr_q + 3'd1;
          if (bit_ctr_q == 3'd7) begin
            rx_data_d  = {shift_rx_q, mosi_s};
            rx_valid_d = 1'b1;
            if (byte_count_q != 8'hFF) byte_count_d = byte_count_q + 8'd1;
          end
        end else if (sck_fall) begin
          if (bit_ctr_q != 3'd0) shift_tx_d = {shift_tx_q[6:0], 1'b0};
          else                   reload     = 1'b1;
        end
      end
      default: state_d = WAIT_CS_HIGH;
    endcase

    // A load arriving on the reload cycle bypasses the empty buffer straight into the shifter
    if (reload) begin
      if (!tx_ready_q) begin
        shift_tx_d = tx_buf_q;
        tx_ready_d = 1'b1;
      end else if (bus.tx_load) begin
        shift_tx_d = bus.tx_data;
      end else begin
        shift_tx_d    = DEFAULT_TX;
        tx_underrun_d = 1'b1;
      end
    end else if (bus.tx_load && tx_ready_q) begin
      tx_buf_d   = bus.tx_data;
      tx_ready_d = 1'b0;
    end
  end

  assign bus.miso        = (state_q == SHIFT) & shift_tx_q[7];
  assign bus.miso_oe     = (state_q == SHIFT);
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.byte_count  = byte_count_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_tdc_spi_slave.sv
// Directed bench for tdc_spi_slave: drives SPI mode-0 frames and checks RX bytes, MISO replies,
// frame strobes, byte counting, underrun and reset behaviour.
module tb_tdc_spi_slave;

  logic clk;
  logic rst;
  tdc_spi_slave_if bus ();

  tdc_spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];

  logic [7:0] mo     [256];
  logic [7:0] mi     [256];
  logic       mid_en [256];
  logic [7:0] mid_d  [256];
  int         rel_idx;
  logic [7:0] rel_d;
  logic       rel_ready;

  int   fs_cnt = 0;
  int   fe_cnt = 0;
  logic uf_at_rv = 1'b0;

  // monitor
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      act_q.push_back(bus.rx_data);
      uf_at_rv = bus.tx_underrun;
    end
    if (bus.frame_start) fs_cnt++;
    if (bus.frame_end)   fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rx_count"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0)
      check({tag, "_rx_byte"}, act_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    wait_clks(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < 256; k++) begin
      mid_en[k] = 1'b0;
      mid_d[k]  = 8'h00;
      mi[k]     = 8'h00;
    end
    rel_idx = -1;
  endtask

  // SPI master driver: phase length ph clk; stops after max_bits; pulses rst after rst_at bits
  task automatic spi_frame(input int nbytes, input int ph, input int max_bits, input int rst_at);
    int bits = 0;
    bus.cs_n_in = 1'b0;
    wait_clks(ph);
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 7; i >= 0; i--) begin
        if (bits < max_bits) begin
          bus.mosi_in = mo[b][i];
          wait_clks(ph);
          mi[b][i] = bus.miso;
          bus.sck_in = 1'b1;
          if (i == 7 && mid_en[b]) pulse_load(mid_d[b]);
          wait_clks(ph);
          bus.sck_in = 1'b0;
          bits++;
          if (i == 0 && b == rel_idx) begin
            wait_clks(2);
            bus.tx_data = rel_d;
            bus.tx_load = 1'b1;
            wait_clks(1);
            bus.tx_load = 1'b0;
            rel_ready   = bus.tx_ready;
          end
          if (bits == rst_at) begin
            rst = 1'b1;
            wait_clks(2);
            rst = 1'b0;
          end
        end
      end
    end
    wait_clks(ph);
    bus.cs_n_in = 1'b1;
    wait_clks(ph + 3);
  endtask

  initial begin
    int fs0, fe0;
    logic [7:0] tx_r [256];
    rst         = 1'b1;
    bus.sck_in  = 1'b0;
    bus.cs_n_in = 1'b1;
    bus.mosi_in = 1'b0;
    bus.tx_load = 1'b0;
    bus.tx_data = 8'h00;
    clear_cfg();
    wait_clks(4);
    rst = 1'b0;

    // reset values
    check("rst_miso", bus.miso, 0);
    check("rst_miso_oe", bus.miso_oe, 0);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_frame_start", bus.frame_start, 0);
    check("rst_frame_end", bus.frame_end, 0);
    check("rst_byte_count", bus.byte_count, 0);
    check("rst_tx_underrun", bus.tx_underrun, 0);
    check("rst_state", bus.state_dbg, 0);
    wait_clks(6);
    check("idle_state", bus.state_dbg, 1);

    // 1: single byte, preloaded reply
    pulse_load(8'hA5);
    wait_clks(1);
    check("t1_tx_ready_full", bus.tx_ready, 0);
    fs0 = fs_cnt; fe0 = fe_cnt;
    mo[0] = 8'h3C;
    exp_q.push_back(8'h3C);
    spi_frame(1, 6, 8, -1);
    check_rx("t1");
    check("t1_miso", mi[0], 8'hA5);
    check("t1_frame_start", fs_cnt - fs0, 1);
    check("t1_frame_end", fe_cnt - fe0, 1);
    check("t1_byte_count", bus.byte_count, 1);
    check("t1_underrun", uf_at_rv, 0);
    check("t1_rx_data", bus.rx_data, 8'h3C);
    check("t1_miso_oe_off", bus.miso_oe, 0);

    // 2: three bytes, third reply underruns
    clear_cfg();
    pulse_load(8'h11);
    mo[0] = 8'h01; mo[1] = 8'h80; mo[2] = 8'hFF;
    mid_en[0] = 1'b1; mid_d[0] = 8'h22;
    exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
    spi_frame(3, 6, 24, -1);
    check_rx("t2");
    check("t2_miso0", mi[0], 8'h11);
    check("t2_miso1", mi[1], 8'h22);
    check("t2_miso2", mi[2], 8'h00);
    check("t2_byte_count", bus.byte_count, 3);
    check("t2_underrun", uf_at_rv, 1);
    check("t2_underrun_sticky", bus.tx_underrun, 1);

    // 3: frame aborted after 5 bits, then a full frame
    clear_cfg();
    fe0 = fe_cnt;
    mo[0] = 8'hE7;
    spi_frame(1, 6, 5, -1);
    check_rx("t3_abort");
    check("t3_frame_end", fe_cnt - fe0, 1);
    check("t3_rx_data_held", bus.rx_data, 8'hFF);
    check("t3_byte_count", bus.byte_count, 0);
    mo[0] = 8'h96;
    exp_q.push_back(8'h96);
    spi_frame(1, 6, 8, -1);
    check_rx("t3_full");

    // 4: reset after 3rd bit with cs_n held low
    clear_cfg();
    fs0 = fs_cnt; fe0 = fe_cnt;
    mo[0] = 8'hC0;
    spi_frame(1, 6, 8, 3);
    check_rx("t4_rst");
    check("t4_frame_start", fs_cnt - fs0, 1);
    check("t4_frame_end", fe_cnt - fe0, 0);
    check("t4_rx_data", bus.rx_data, 8'h00);
    check("t4_byte_count", bus.byte_count, 0);
    check("t4_underrun", bus.tx_underrun, 0);
    check("t4_state", bus.state_dbg, 1);
    mo[0] = 8'h5A;
    exp_q.push_back(8'h5A);
    spi_frame(1, 6, 8, -1);
    check_rx("t4_new");
    check("t4_rx_data_new", bus.rx_data, 8'h5A);

    // 5: load exactly on the byte-boundary reload cycle
    clear_cfg();
    pulse_load(8'h69);
    mo[0] = 8'h12; mo[1] = 8'h34;
    rel_idx = 0; rel_d = 8'hC3; rel_ready = 1'b0;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    spi_frame(2, 6, 16, -1);
    check_rx("t5");
    check("t5_miso0", mi[0], 8'h69);
    check("t5_miso1", mi[1], 8'hC3);
    check("t5_ready_after_reload", rel_ready, 1);
    check("t5_underrun", uf_at_rv, 0);
    clear_cfg();
    pulse_load(8'h77);
    check("t5_ready_full", bus.tx_ready, 0);
    pulse_load(8'h99);
    check("t5_ready_still_full", bus.tx_ready, 0);
    mo[0] = 8'h00;
    exp_q.push_back(8'h00);
    spi_frame(1, 6, 8, -1);
    check_rx("t5_ignored");
    check("t5_miso_kept", mi[0], 8'h77);

    // 6: 256 random bytes at the fastest supported sck phase
    clear_cfg();
    for (int k = 0; k < 256; k++) begin
      mo[k]   = 8'($urandom_range(0, 255));
      tx_r[k] = 8'($urandom_range(0, 255));
      exp_q.push_back(mo[k]);
    end
    for (int k = 0; k < 255; k++) begin
      mid_en[k] = 1'b1;
      mid_d[k]  = tx_r[k+1];
    end
    pulse_load(tx_r[0]);
    spi_frame(256, 5, 2048, -1);
    check_rx("t6");
    for (int k = 0; k < 256; k++) check($sformatf("t6_miso%0d", k), mi[k], tx_r[k]);
    check("t6_byte_count_sat", bus.byte_count, 255);
    check("t6_underrun", uf_at_rv, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
